sd_spi_byte_engine: RTL and testbench

- SPI mode-0 byte transceiver sitting directly below the SD card controller, driving the physical SD_CLK/SD_MOSI/SD_CS pins and sampling SD_MISO.
- The controller issues one byte per iStart. The engine shifts it out MSB-first while shifting in the card's response, then pulses oDone.
- Supports a slow clock for card init (about 400 kHz) and a fast clock for data transfer, selected per byte.

---
 rtl/sd_spi_byte_engine.sv | 129 ++++++++++++
 tb/tb_sd_spi_byte_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte transceiver for the SD card pins: shifts one byte out on SD_MOSI
// MSB-first while shifting SD_MISO in, with a slow/fast SD_CLK divider chosen per byte.
module sd_spi_byte_engine #(
  parameter int SLOW_DIV = 63,
  parameter int FAST_DIV = 2,
  parameter int DIV_W    = 8
) (
  input  logic       iCLK,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iTxByte,
  input  logic       iSlow,
  input  logic       iCsAssert,
  output logic [7:0] oRxByte,
  output logic       oBusy,
  output logic       oDone,
  output logic       SD_CLK,
  output logic       SD_MOSI,
  input  logic       SD_MISO,
  output logic       SD_CS
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Terminal counts; a divider of 0 behaves like 1.
  localparam logic [DIV_W-1:0] SLOW_TC = (SLOW_DIV <= 1) ? {DIV_W{1'b0}} : DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_TC = (FAST_DIV <= 1) ? {DIV_W{1'b0}} : DIV_W'(FAST_DIV - 1);

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [6:0]       tx_sh_r;
  logic [7:0]       rx_sh_r;
  logic [2:0]       bitcnt_r;
  logic             slow_r;
  logic             phase_end_s;

  // Last cycle of the current SD_CLK half-period for the latched divider.
  always_comb begin
    phase_end_s = 1'b0;
    if (slow_r) begin
      phase_end_s = (div_cnt_r == SLOW_TC);
    end else begin
      phase_end_s = (div_cnt_r == FAST_TC);
    end
  end

  // Byte sequencer driving every registered output and pin.
  always_ff @(posedge iCLK or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= {DIV_W{1'b0}};
      tx_sh_r   <= 7'd0;
      rx_sh_r   <= 8'd0;
      bitcnt_r  <= 3'd0;
      slow_r    <= 1'b0;
      oRxByte   <= 8'h00;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      SD_CLK    <= 1'b0;
      SD_MOSI   <= 1'b1;
      SD_CS     <= 1'b1;
    end else begin
      oDone <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          SD_CLK  <= 1'b0;
          SD_MOSI <= 1'b1;
          SD_CS   <= ~iCsAssert;
          // oBusy still high here means this is the oDone cycle: iStart is not sampled.
          if (oBusy) begin
            oBusy <= 1'b0;
          end else if (iStart) begin
            tx_sh_r   <= iTxByte[6:0];
            slow_r    <= iSlow;
            SD_MOSI   <= iTxByte[7];
            bitcnt_r  <= 3'd7;
            div_cnt_r <= {DIV_W{1'b0}};
            oBusy     <= 1'b1;
            state_r   <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (phase_end_s) begin
            SD_CLK    <= 1'b1;
            rx_sh_r   <= {rx_sh_r[6:0], SD_MISO};
            div_cnt_r <= {DIV_W{1'b0}};
            state_r   <= ST_HIGH;
          end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HIGH: begin
          if (phase_end_s) begin
            SD_CLK    <= 1'b0;
            div_cnt_r <= {DIV_W{1'b0}};
            if (bitcnt_r == 3'd0) begin
              state_r <= ST_DONE;
            end else begin
              bitcnt_r <= bitcnt_r - 3'd1;
              SD_MOSI  <= tx_sh_r[6];
              tx_sh_r  <= {tx_sh_r[5:0], 1'b0};
              state_r  <= ST_LOW;
            end
          end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          oRxByte <= rx_sh_r;
          oDone   <= 1'b1;
          SD_MOSI <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          SD_CLK  <= 1'b0;
          SD_MOSI <= 1'b1;
          oBusy   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_byte_engine.sv
// Self-checking bench for sd_spi_byte_engine: a card model feeds MISO and a pin
// monitor measures SD_CLK phases, MOSI bits and oDone timing against spec arithmetic.
module tb_sd_spi_byte_engine;

  logic       iCLK = 1'b0;
  logic       Reset = 1'b0;
  logic       iStart = 1'b0;
  logic [7:0] iTxByte = 8'h00;
  logic       iSlow = 1'b0;
  logic       iCsAssert = 1'b1;
  logic       SD_MISO = 1'b1;
  logic [7:0] oRxByte;
  logic       oBusy, oDone, SD_CLK, SD_MOSI, SD_CS;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Monitor / card-model state, owned by the single test process.
  int         rises = 0, falls = 0, dones = 0, last_edge = 0, phase_bad = 0, cs_bad = 0;
  int         cur_div = 2;
  logic       prev_clk = 1'b0;
  logic [7:0] mosi_seen = 8'h00;
  logic [7:0] resp_q = 8'h00;

  sd_spi_byte_engine #(.SLOW_DIV(63), .FAST_DIV(2), .DIV_W(8)) dut (
    .iCLK(iCLK), .Reset(Reset), .iStart(iStart), .iTxByte(iTxByte), .iSlow(iSlow),
    .iCsAssert(iCsAssert), .oRxByte(oRxByte), .oBusy(oBusy), .oDone(oDone),
    .SD_CLK(SD_CLK), .SD_MOSI(SD_MOSI), .SD_MISO(SD_MISO), .SD_CS(SD_CS)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) edge_cnt <= edge_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mon_clear(input logic [7:0] resp, input int div, input int start_edge);
    rises = 0; falls = 0; dones = 0; phase_bad = 0; cs_bad = 0;
    mosi_seen = 8'h00; resp_q = resp; cur_div = div; last_edge = start_edge;
    SD_MISO = resp[7];
    prev_clk = SD_CLK;
  endtask

  // Advance one cycle, sample away from the active edge and update the card model.
  task automatic step();
    @(negedge iCLK);
    #1;
    if (SD_CLK && !prev_clk) begin
      if (edge_cnt - last_edge != cur_div) phase_bad++;
      last_edge = edge_cnt;
      mosi_seen = {mosi_seen[6:0], SD_MOSI};
      rises++;
      if (rises < 8) SD_MISO = resp_q[7 - rises];
      else SD_MISO = 1'b1;
    end else if (!SD_CLK && prev_clk) begin
      if (edge_cnt - last_edge != cur_div) phase_bad++;
      last_edge = edge_cnt;
      falls++;
    end
    prev_clk = SD_CLK;
    if (oDone) dones++;
    if (oBusy && SD_CS) cs_bad++;
  endtask

  // One complete byte; optionally disturbs iStart or iCsAssert once inj_rise SD_CLK rises are seen.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] resp, input logic slow,
                      input int inj_rise, input logic inj_cs, input string tag);
    int   div, acc, lat, n;
    logic got, injected;
    div = slow ? 63 : 2;
    iTxByte = tx; iSlow = slow; iStart = 1'b1;
    acc = edge_cnt + 1;
    mon_clear(resp, div, acc);
    step();
    iStart = 1'b0; iTxByte = ~tx; iSlow = ~slow;
    checks++;
    if (oBusy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b expected 1", tag, oBusy); end
    got = 1'b0; injected = 1'b0; n = 0;
    while (!got && n < 20 * div + 40) begin
      iStart = 1'b0;
      if (inj_rise >= 0 && !injected && rises == inj_rise) begin
        injected = 1'b1;
        if (inj_cs) iCsAssert = 1'b0;
        else begin iStart = 1'b1; iTxByte = 8'h00; end
      end
      step();
      n++;
      if (oDone === 1'b1) got = 1'b1;
    end
    iStart = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout: got no oDone expected one within %0d cycles", tag, n); end
    lat = edge_cnt - acc;
    checks++;
    if (lat != 16 * div + 1) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, 16 * div + 1); end
    checks++;
    if (oRxByte !== resp) begin errors++; $display("FAIL %s rx_byte: got %h expected %h", tag, oRxByte, resp); end
    checks++;
    if (mosi_seen !== tx) begin errors++; $display("FAIL %s mosi_bits: got %h expected %h", tag, mosi_seen, tx); end
    checks++;
    if (rises != 8 || falls != 8) begin errors++; $display("FAIL %s sclk_edges: got %0d rises %0d falls expected 8 8", tag, rises, falls); end
    checks++;
    if (phase_bad != 0) begin errors++; $display("FAIL %s phase_len: got %0d bad phases expected 0 (div %0d)", tag, phase_bad, div); end
    checks++;
    if (cs_bad != 0) begin errors++; $display("FAIL %s cs_during_byte: got %0d cycles with CS high expected 0", tag, cs_bad); end
    step();
    checks++;
    if (oDone !== 1'b0 || dones != 1) begin errors++; $display("FAIL %s done_pulse: got oDone=%b pulses=%0d expected 0 1", tag, oDone, dones); end
    checks++;
    if (oBusy !== 1'b0 || SD_CLK !== 1'b0 || SD_MOSI !== 1'b1) begin
      errors++; $display("FAIL %s idle_after: got busy=%b clk=%b mosi=%b expected 0 0 1", tag, oBusy, SD_CLK, SD_MOSI);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; iCsAssert = 1'b1;
    repeat (3) step();
    checks++;
    if ({SD_CLK, SD_MOSI, SD_CS, oBusy, oDone} !== 5'b01100 || oRxByte !== 8'h00) begin
      errors++; $display("FAIL reset_values: got clk/mosi/cs/busy/done=%b rx=%h expected 01100 00", {SD_CLK, SD_MOSI, SD_CS, oBusy, oDone}, oRxByte);
    end
    Reset = 1'b1;
    repeat (2) step();
    checks++;
    if (SD_CS !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL idle_cs_follow: got cs=%b busy=%b expected 0 0", SD_CS, oBusy); end
  endtask

  task automatic test_fast();
    xfer(8'hA5, 8'h3C, 1'b0, -1, 1'b0, "fast_a5");
  endtask

  task automatic test_slow();
    xfer(8'hFF, 8'h81, 1'b1, -1, 1'b0, "slow_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      xfer(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0, -1, 1'b0, "rand");
    end
  endtask

  task automatic test_ignore_start();
    xfer(8'($urandom_range(255)), 8'h5A, 1'b0, 4, 1'b0, "ignore_start");
    repeat (6) step();
    checks++;
    if (rises != 8 || dones != 1 || oBusy !== 1'b0) begin
      errors++; $display("FAIL ignore_not_queued: got rises=%0d dones=%0d busy=%b expected 8 1 0", rises, dones, oBusy);
    end
    xfer(8'h3E, 8'hC7, 1'b0, -1, 1'b0, "after_ignore");
  endtask

  task automatic test_cs_defer();
    iCsAssert = 1'b1;
    xfer(8'h6B, 8'h12, 1'b0, 3, 1'b1, "cs_defer");
    checks++;
    if (SD_CS !== 1'b1) begin errors++; $display("FAIL cs_release_idle: got %b expected 1", SD_CS); end
    iCsAssert = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    xfer(8'h40, 8'hE1, 1'b0, -1, 1'b0, "b2b_first");
    xfer(8'h95, 8'h2D, 1'b0, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int n;
    iTxByte = 8'hC3; iSlow = 1'b0; iStart = 1'b1;
    mon_clear(8'h77, 2, edge_cnt + 1);
    step();
    iStart = 1'b0;
    n = 0;
    while (rises < 3 && n < 100) begin step(); n++; end
    checks++;
    if (rises != 3) begin errors++; $display("FAIL mid_reset_reach: got %0d rises expected 3", rises); end
    Reset = 1'b0;
    #1;
    checks++;
    if ({SD_CLK, SD_MOSI, SD_CS, oBusy, oDone} !== 5'b01100 || oRxByte !== 8'h00) begin
      errors++; $display("FAIL mid_reset_values: got clk/mosi/cs/busy/done=%b rx=%h expected 01100 00", {SD_CLK, SD_MOSI, SD_CS, oBusy, oDone}, oRxByte);
    end
    repeat (4) step();
    Reset = 1'b1;
    repeat (40) step();
    checks++;
    if (dones != 0 || oBusy !== 1'b0 || SD_CLK !== 1'b0) begin
      errors++; $display("FAIL mid_reset_abort: got dones=%0d busy=%b clk=%b expected 0 0 0", dones, oBusy, SD_CLK);
    end
    xfer(8'($urandom_range(255)), 8'hB4, 1'b0, -1, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_random();
    test_ignore_start();
    test_cs_defer();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
